execute: RTL and testbench
==========================

# execute

Execute stage of the 16-bit HybridCore pipeline. It takes one decoded instruction per cycle from decode, forwards operands from its own registered output and from the writeback bypass, and computes the result and NZCV flags. It holds the flags register and runs a 16-cycle iterative multiplier that stalls decode. Its registered outputs feed writeback directly.

## Interface
- DATA_W, 16, datapath width; only 16 is supported.
- MUL_CYCLES, 16, busy cycles for MUL; equals DATA_W.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- id_ex_valid  in  1  decode presents an instruction.
- id_ex_op  in  5  opcode (encoding below).
- id_ex_reg_idx_a  in  5  source-A register index.
- id_ex_reg_idx_b  in  5  source-B register index.
- id_ex_b_is_reg  in  1  operand B came from a register (forwardable).
- id_ex_reg_idx_dst  in  5  destination index.
- id_ex_operand_a  in  16  register-file value of A.
- id_ex_operand_b  in  16  register-file value or immediate for B.
- wb_ex_has_bypass  in  1  writeback is writing a register this cycle.
- wb_ex_bypass_reg  in  5  index being written by writeback.
- wb_ex_bypass_value  in  16  value being written by writeback.
- ex_id_stall  out  1  execute cannot accept; decode holds its inputs.
- ex_wb_valid  out  1  ex_wb_* holds a valid instruction.
- ex_wb_op  out  5  registered opcode.
- ex_wb_result  out  16  registered result.
- ex_wb_nzcv  out  4  flags after the instruction, {N,Z,C,V}.
- ex_wb_reg_idx_dst  out  5  registered destination.
- ex_wb_operand_b  out  16  registered forwarded B (store data).

## Operation
- Opcodes: 00000 ADD, 00001 ADC, 00010 SUB, 00011 SBC, 00100 AND, 00101 OR, 00110 XOR, 00111 NOT(A), 01000 LSL, 01001 LSR, 01010 ASR, 01011 ROR, 01100 MUL, 01101 INC(A), 01110 DEC(A), 01111 CMP, 10000 MOV, 10001 NOP, 10010 LD, 10011 STR, 10100 MSR, 10101 MRS, 10110 PUSH, 10111 POP; 11xxx treated as NOP.
- Register-writing ops: 00000–01110, 10000, 10010, 10100, 10101, 10111.
- Forwarding, A always, B only when id_ex_b_is_reg:
  - Priority 1: ex_wb_valid && ex_wb_op is register-writing && ex_wb_reg_idx_dst matches → ex_wb_result.
  - Priority 2: wb_ex_has_bypass && wb_ex_bypass_reg matches → wb_ex_bypass_value.
  - Otherwise: the id_ex operand.
- Arithmetic is 17-bit. C = carry out, or NOT borrow for SUB/SBC/CMP/DEC. V = signed overflow.
- ADC adds C. SBC computes A−B−!C.
- Shifts use amount B[3:0]. C = last bit shifted out; amount 0 leaves C unchanged. V unchanged.
- Logic ops, NOT and MUL: C and V unchanged.
- N and Z are computed from the 16-bit result for every flag-setting op.
- CMP computes SUB flags only; its result is the SUB value and is not written.
- Flag-setting ops: 00000–01111. MSR loads flags from A[3:0]. All other ops hold the flags.
- Non-ALU results:
  - MOV: B.
  - LD, STR, PUSH, POP: A (address/data per writeback).
  - MSR: A.
  - MRS: {12'b0, flags}.
  - NOP: 0.
- ex_wb_operand_b is always the forwarded B.
- FSM:
  - IDLE: accept when id_ex_valid. Non-MUL ops register their outputs at that edge. MUL latches forwarded A/B, clears the accumulator and counter, and moves to MUL.
  - MUL: each edge adds the shifted multiplicand when multiplier bit[count] is set; count increments. At the edge where count==15, register the low 16 bits, set ex_wb_valid, and return to IDLE.
- ex_id_stall = (state==MUL). Decode holds a stable instruction during stall; it is accepted at the first IDLE edge.
- The bypass window for a MUL operand in flight is not re-evaluated.

## Timing
- Reset values: state IDLE, flags 0000, ex_wb_valid 0, ex_wb_op 10001, and ex_wb_result, ex_wb_nzcv, ex_wb_reg_idx_dst, ex_wb_operand_b all 0. ex_id_stall = 0.
- Non-MUL latency: 1. Accepted at edge t, ex_wb_* valid from t to t+1.
- MUL latency: 16. Accepted at edge t, result at edge t+16.
  - ex_id_stall is high for cycles t..t+16.
  - ex_wb_valid is 0 from t+1 to t+16.
- ex_wb_valid drops to 0 on any edge with no accept and no MUL completion. The outputs hold their last values, and ex_wb_op is forced to NOP.
- Reset mid-MUL aborts the multiply and produces no output.
- Back-to-back dependent ops forward through priority 1 with zero bubbles.

## Test plan
- Back-to-back ADD: ADD r1=0x7FFF+0x0001, then ADD r2=r1+r1 with stale regfile values → results 0x8000 (NZCV=1001) and 0x0000 (NZCV=0111, forwarded from EX).
- Bypass priority: EX holds r3=0x1111 and the WB bypass offers r3=0x2222 → operand uses 0x1111. With no matching EX entry → 0x2222.
- Multiply: MUL 0x0123×0x0045 → result 0x4E6F. ex_id_stall is high for exactly 16 cycles. The next instruction, held by decode, completes one cycle after the MUL result.
- Flag ops: SUB 5−7 → 0xFFFE, NZCV=1000. CMP 7,7 → Z=1 and C=1 with no register write. ADC 0xFFFF+0 with C=1 → 0x0000, C=1.
- Shifts: LSR 0x8001 by 1 → 0x4000, C=1. ASR 0x8000 by 15 → 0xFFFF. Shift by 0 keeps C.
- Reset mid-MUL: assert reset at busy cycle 8 → all outputs at reset values immediately (asynchronous), ex_wb_valid never pulses, and the next instruction after reset executes normally.

Source files
------------

// File: rtl/execute_if.sv
`timescale 1ns/1ps
// execute_if: decode/writeback <-> execute stage bundle.
//   id_ex_*  : decoded instruction and register-file operands from decode
//   wb_ex_*  : writeback register bypass into execute
//   ex_id_*  : stall back to decode
//   ex_wb_*  : registered execute results toward writeback
// master = decode/writeback side, slave = execute stage.
interface execute_if #(
   parameter int DATA_W = 16
);
   logic              id_ex_valid;
   logic [4:0]        id_ex_op;
   logic [4:0]        id_ex_reg_idx_a;
   logic [4:0]        id_ex_reg_idx_b;
   logic              id_ex_b_is_reg;
   logic [4:0]        id_ex_reg_idx_dst;
   logic [DATA_W-1:0] id_ex_operand_a;
   logic [DATA_W-1:0] id_ex_operand_b;
   logic              wb_ex_has_bypass;
   logic [4:0]        wb_ex_bypass_reg;
   logic [DATA_W-1:0] wb_ex_bypass_value;
   logic              ex_id_stall;
   logic              ex_wb_valid;
   logic [4:0]        ex_wb_op;
   logic [DATA_W-1:0] ex_wb_result;
   logic [3:0]        ex_wb_nzcv;
   logic [4:0]        ex_wb_reg_idx_dst;
   logic [DATA_W-1:0] ex_wb_operand_b;

   modport master (
      output id_ex_valid, id_ex_op, id_ex_reg_idx_a, id_ex_reg_idx_b, id_ex_b_is_reg,
             id_ex_reg_idx_dst, id_ex_operand_a, id_ex_operand_b,
             wb_ex_has_bypass, wb_ex_bypass_reg, wb_ex_bypass_value,
      input  ex_id_stall, ex_wb_valid, ex_wb_op, ex_wb_result, ex_wb_nzcv,
             ex_wb_reg_idx_dst, ex_wb_operand_b
   );

   modport slave (
      input  id_ex_valid, id_ex_op, id_ex_reg_idx_a, id_ex_reg_idx_b, id_ex_b_is_reg,
             id_ex_reg_idx_dst, id_ex_operand_a, id_ex_operand_b,
             wb_ex_has_bypass, wb_ex_bypass_reg, wb_ex_bypass_value,
      output ex_id_stall, ex_wb_valid, ex_wb_op, ex_wb_result, ex_wb_nzcv,
             ex_wb_reg_idx_dst, ex_wb_operand_b
   );
endinterface

// File: rtl/execute.sv
`timescale 1ns/1ps
// execute: execute stage of the 16-bit HybridCore pipeline.
// Forwards operands (EX result first, then WB bypass), computes the ALU
// result and NZCV flags, holds the flags register and runs a 16-cycle
// shift-add multiplier that stalls decode while busy.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : execute_if.slave (id_ex_* in, wb_ex_* in, ex_id_stall out, ex_wb_* out)
module execute #(
   parameter int DATA_W     = 16,
   parameter int MUL_CYCLES = 16
) (
   input logic      clk,
   input logic      reset,
   execute_if.slave bus
);
   localparam int CNT_W = $clog2(MUL_CYCLES);

   localparam logic [4:0] OP_ADD = 5'b00000, OP_ADC = 5'b00001, OP_SUB = 5'b00010,
                          OP_SBC = 5'b00011, OP_AND = 5'b00100, OP_OR  = 5'b00101,
                          OP_XOR = 5'b00110, OP_NOT = 5'b00111, OP_LSL = 5'b01000,
                          OP_LSR = 5'b01001, OP_ASR = 5'b01010, OP_ROR = 5'b01011,
                          OP_MUL = 5'b01100, OP_INC = 5'b01101, OP_DEC = 5'b01110,
                          OP_CMP = 5'b01111, OP_MOV = 5'b10000, OP_NOP = 5'b10001,
                          OP_LD  = 5'b10010, OP_STR = 5'b10011, OP_MSR = 5'b10100,
                          OP_MRS = 5'b10101, OP_PSH = 5'b10110, OP_POP = 5'b10111;

   typedef enum logic {S_IDLE, S_MUL} state_t;

   function automatic logic writes_reg(input logic [4:0] op);
      return (op <= OP_DEC) || (op == OP_MOV) || (op == OP_LD) ||
             (op == OP_MSR) || (op == OP_MRS) || (op == OP_POP);
   endfunction

   // N and Z from the result; C and V supplied by the caller.
   function automatic logic [3:0] mk_flags(input logic [DATA_W-1:0] r, input logic c,
                                            input logic v);
      return {r[DATA_W-1], (r == '0), c, v};
   endfunction

   state_t            state, state_nxt;
   logic [3:0]        flags;
   logic              accept, stall;
   logic [DATA_W-1:0] fwd_a_p0, fwd_b_p0;
   logic              ex_fwd_ok;

   logic [DATA_W-1:0] addend;
   logic              cin, add_v;
   logic [DATA_W:0]   sum;
   logic [3:0]        sh_amt;
   logic [DATA_W:0]   shl_ext, shr_ext;
   logic signed [DATA_W:0] asr_ext;
   logic [DATA_W-1:0] ror_res;
   logic              sh_c;
   logic [DATA_W-1:0] alu_res;
   logic [3:0]        alu_flags;

   logic [CNT_W-1:0]  mul_cnt_p1;
   logic [DATA_W-1:0] mul_a_p1, mul_b_p1, mul_acc_p1, mul_acc_nxt;
   logic [4:0]        mul_dst_p1;
   logic              mul_last;

   // Operand forwarding: EX output beats the WB bypass, which beats the regfile.
   assign ex_fwd_ok = bus.ex_wb_valid && writes_reg(bus.ex_wb_op);

   always_comb begin
      fwd_a_p0 = bus.id_ex_operand_a;
      if (ex_fwd_ok && (bus.ex_wb_reg_idx_dst == bus.id_ex_reg_idx_a))
         fwd_a_p0 = bus.ex_wb_result;
      else if (bus.wb_ex_has_bypass && (bus.wb_ex_bypass_reg == bus.id_ex_reg_idx_a))
         fwd_a_p0 = bus.wb_ex_bypass_value;
      fwd_b_p0 = bus.id_ex_operand_b;
      if (bus.id_ex_b_is_reg) begin
         if (ex_fwd_ok && (bus.ex_wb_reg_idx_dst == bus.id_ex_reg_idx_b))
            fwd_b_p0 = bus.ex_wb_result;
         else if (bus.wb_ex_has_bypass && (bus.wb_ex_bypass_reg == bus.id_ex_reg_idx_b))
            fwd_b_p0 = bus.wb_ex_bypass_value;
      end
   end

   // One shared 17-bit adder; subtraction-type ops add ~B + 1 (or + C),
   // so the carry out is already NOT borrow.
   always_comb begin
      addend = fwd_b_p0;
      cin    = 1'b0;
      case (bus.id_ex_op)
         OP_ADC:         cin = flags[1];
         OP_SUB, OP_CMP: begin addend = ~fwd_b_p0; cin = 1'b1;     end
         OP_SBC:         begin addend = ~fwd_b_p0; cin = flags[1]; end
         OP_INC:         begin addend = '0;        cin = 1'b1;     end
         OP_DEC:         begin addend = '1;        cin = 1'b0;     end
         default: ;
      endcase
      sum   = {1'b0, fwd_a_p0} + {1'b0, addend} + {{DATA_W{1'b0}}, cin};
      add_v = (fwd_a_p0[DATA_W-1] == addend[DATA_W-1]) &&
              (sum[DATA_W-1] != fwd_a_p0[DATA_W-1]);
   end

   // Shifters carry one extra bit to capture the last bit shifted out.
   assign sh_amt  = fwd_b_p0[3:0];
   assign shl_ext = {1'b0, fwd_a_p0} << sh_amt;
   assign shr_ext = {fwd_a_p0, 1'b0} >> sh_amt;
   assign asr_ext = $signed({fwd_a_p0, 1'b0}) >>> sh_amt;
   assign ror_res = DATA_W'({fwd_a_p0, fwd_a_p0} >> sh_amt);

   always_comb begin
      alu_res   = '0;
      alu_flags = flags;
      sh_c      = flags[1];
      case (bus.id_ex_op)
         OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CMP, OP_INC, OP_DEC: begin
            alu_res   = sum[DATA_W-1:0];
            alu_flags = mk_flags(alu_res, sum[DATA_W], add_v);
         end
         OP_AND: begin alu_res = fwd_a_p0 & fwd_b_p0; alu_flags = mk_flags(alu_res, flags[1], flags[0]); end
         OP_OR:  begin alu_res = fwd_a_p0 | fwd_b_p0; alu_flags = mk_flags(alu_res, flags[1], flags[0]); end
         OP_XOR: begin alu_res = fwd_a_p0 ^ fwd_b_p0; alu_flags = mk_flags(alu_res, flags[1], flags[0]); end
         OP_NOT: begin alu_res = ~fwd_a_p0;           alu_flags = mk_flags(alu_res, flags[1], flags[0]); end
         OP_LSL, OP_LSR, OP_ASR, OP_ROR: begin
            case (bus.id_ex_op)
               OP_LSL:  begin alu_res = shl_ext[DATA_W-1:0]; sh_c = shl_ext[DATA_W]; end
               OP_LSR:  begin alu_res = shr_ext[DATA_W:1];   sh_c = shr_ext[0];      end
               OP_ASR:  begin alu_res = asr_ext[DATA_W:1];   sh_c = asr_ext[0];      end
               default: begin alu_res = ror_res;             sh_c = shr_ext[0];      end
            endcase
            if (sh_amt == 4'd0) sh_c = flags[1];
            alu_flags = mk_flags(alu_res, sh_c, flags[0]);
         end
         OP_MOV:                         alu_res = fwd_b_p0;
         OP_LD, OP_STR, OP_PSH, OP_POP:  alu_res = fwd_a_p0;
         OP_MSR: begin alu_res = fwd_a_p0; alu_flags = fwd_a_p0[3:0]; end
         OP_MRS:                         alu_res = {{(DATA_W-4){1'b0}}, flags};
         default: ;
      endcase
   end

   // Shift-add multiplier step: add A << count when B[count] is set.
   assign mul_acc_nxt = mul_acc_p1 + (mul_b_p1[mul_cnt_p1] ? (mul_a_p1 << mul_cnt_p1) : '0);
   assign mul_last    = (mul_cnt_p1 == CNT_W'(MUL_CYCLES - 1));

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      stall     = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.id_ex_valid) begin
               accept = 1'b1;
               if (bus.id_ex_op == OP_MUL) state_nxt = S_MUL;
            end
         end
         S_MUL: begin
            stall = 1'b1;
            if (mul_last) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign bus.ex_id_stall = stall;

   // p0 -> EX/WB registers, flags and FSM state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state                 <= S_IDLE;
         flags                 <= 4'b0000;
         mul_cnt_p1            <= '0;
         bus.ex_wb_valid       <= 1'b0;
         bus.ex_wb_op          <= OP_NOP;
         bus.ex_wb_result      <= '0;
         bus.ex_wb_nzcv        <= 4'b0000;
         bus.ex_wb_reg_idx_dst <= '0;
         bus.ex_wb_operand_b   <= '0;
      end else begin
         state           <= state_nxt;
         bus.ex_wb_valid <= 1'b0;
         bus.ex_wb_op    <= OP_NOP;
         if (accept && (bus.id_ex_op == OP_MUL)) begin
            mul_cnt_p1 <= '0;
         end else if (accept) begin
            bus.ex_wb_valid       <= 1'b1;
            bus.ex_wb_op          <= bus.id_ex_op;
            bus.ex_wb_result      <= alu_res;
            bus.ex_wb_nzcv        <= alu_flags;
            bus.ex_wb_reg_idx_dst <= bus.id_ex_reg_idx_dst;
            bus.ex_wb_operand_b   <= fwd_b_p0;
            flags                 <= alu_flags;
         end else if (state == S_MUL) begin
            mul_cnt_p1 <= mul_cnt_p1 + 1'b1;
            if (mul_last) begin
               bus.ex_wb_valid       <= 1'b1;
               bus.ex_wb_op          <= OP_MUL;
               bus.ex_wb_result      <= mul_acc_nxt;
               bus.ex_wb_nzcv        <= mk_flags(mul_acc_nxt, flags[1], flags[0]);
               bus.ex_wb_reg_idx_dst <= mul_dst_p1;
               bus.ex_wb_operand_b   <= mul_b_p1;
               flags                 <= mk_flags(mul_acc_nxt, flags[1], flags[0]);
            end
         end
      end
   end

   // p0 -> p1 multiplier operands and accumulator
   always_ff @(posedge clk) begin
      if (accept && (bus.id_ex_op == OP_MUL)) begin
         mul_a_p1   <= fwd_a_p0;
         mul_b_p1   <= fwd_b_p0;
         mul_dst_p1 <= bus.id_ex_reg_idx_dst;
         mul_acc_p1 <= '0;
      end else if (state == S_MUL) begin
         mul_acc_p1 <= mul_acc_nxt;
      end
   end
endmodule

// File: tb/tb_execute.sv
`timescale 1ns/1ps
module tb_execute;
   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   execute_if bus ();

   execute dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [4:0] ADD = 5'b00000, ADC = 5'b00001, SUB = 5'b00010, ORR = 5'b00101,
                          AND_ = 5'b00100, LSL = 5'b01000, LSR = 5'b01001, ASR = 5'b01010,
                          ROR = 5'b01011, MUL = 5'b01100, CMP = 5'b01111, MOV = 5'b10000,
                          NOP = 5'b10001, MSR = 5'b10100, MRS = 5'b10101;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] op, input logic [4:0] ia, input logic [4:0] ib,
                        input logic bir, input logic [4:0] dst, input logic [15:0] a,
                        input logic [15:0] b);
      bus.id_ex_valid       = 1'b1;
      bus.id_ex_op          = op;
      bus.id_ex_reg_idx_a   = ia;
      bus.id_ex_reg_idx_b   = ib;
      bus.id_ex_b_is_reg    = bir;
      bus.id_ex_reg_idx_dst = dst;
      bus.id_ex_operand_a   = a;
      bus.id_ex_operand_b   = b;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      n_checks++; if (bus.ex_wb_valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid got=%b exp=0", bus.ex_wb_valid); end
      n_checks++; if (bus.ex_wb_op !== NOP) begin n_errors++; $display("FAIL rst_op got=%b exp=%b", bus.ex_wb_op, NOP); end
      n_checks++; if (bus.ex_wb_result !== 16'h0000) begin n_errors++; $display("FAIL rst_result got=%h exp=0000", bus.ex_wb_result); end
      n_checks++; if (bus.ex_wb_nzcv !== 4'b0000) begin n_errors++; $display("FAIL rst_nzcv got=%b exp=0000", bus.ex_wb_nzcv); end
      n_checks++; if (bus.ex_id_stall !== 1'b0) begin n_errors++; $display("FAIL rst_stall got=%b exp=0", bus.ex_id_stall); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      drive(ADD, 5'd5, 5'd6, 1'b1, 5'd1, 16'h7FFF, 16'h0001);
      tick();
      n_checks++; if (bus.ex_wb_result !== 16'h8000) begin n_errors++; $display("FAIL b2b_res1 got=%h exp=8000", bus.ex_wb_result); end
      n_checks++; if (bus.ex_wb_nzcv !== 4'b1001) begin n_errors++; $display("FAIL b2b_nzcv1 got=%b exp=1001", bus.ex_wb_nzcv); end
      n_checks++; if (bus.ex_wb_valid !== 1'b1) begin n_errors++; $display("FAIL b2b_valid1 got=%b exp=1", bus.ex_wb_valid); end
      drive(ADD, 5'd1, 5'd1, 1'b1, 5'd2, 16'h0000, 16'h0000);
      tick();
      n_checks++; if (bus.ex_wb_result !== 16'h0000) begin n_errors++; $display("FAIL b2b_res2 got=%h exp=0000", bus.ex_wb_result); end
      n_checks++; if (bus.ex_wb_nzcv !== 4'b0111) begin n_errors++; $display("FAIL b2b_nzcv2 got=%b exp=0111", bus.ex_wb_nzcv); end
      n_checks++; if (bus.ex_wb_operand_b !== 16'h8000) begin n_errors++; $display("FAIL b2b_opb got=%h exp=8000", bus.ex_wb_operand_b); end
      n_checks++; if (bus.ex_wb_reg_idx_dst !== 5'd2) begin n_errors++; $display("FAIL b2b_dst got=%0d exp=2", bus.ex_wb_reg_idx_dst); end
      bus.id_ex_valid = 1'b0;
      tick();
      n_checks++; if (bus.ex_wb_valid !== 1'b0) begin n_errors++; $display("FAIL idle_valid got=%b exp=0", bus.ex_wb_valid); end
      n_checks++; if (bus.ex_wb_op !== NOP) begin n_errors++; $display("FAIL idle_op got=%b exp=%b", bus.ex_wb_op, NOP); end
      n_checks++; if (bus.ex_wb_nzcv !== 4'b0111) begin n_errors++; $display("FAIL idle_hold got=%b exp=0111", bus.ex_wb_nzcv); end
   endtask

   task automatic test_bypass();
      drive(MOV, 5'd20, 5'd21, 1'b0, 5'd3, 16'h0000, 16'h1111);
      tick();
      bus.wb_ex_has_bypass   = 1'b1;
      bus.wb_ex_bypass_reg   = 5'd3;
      bus.wb_ex_bypass_value = 16'h2222;
      drive(ORR, 5'd3, 5'd21, 1'b0, 5'd4, 16'h5555, 16'h0000);
      tick();
      n_checks++; if (bus.ex_wb_result !== 16'h1111) begin n_errors++; $display("FAIL byp_ex_prio got=%h exp=1111", bus.ex_wb_result); end
      n_checks++; if (bus.ex_wb_nzcv !== 4'b0011) begin n_errors++; $display("FAIL byp_nzcv got=%b exp=0011", bus.ex_wb_nzcv); end
      drive(ORR, 5'd3, 5'd21, 1'b0, 5'd5, 16'h5555, 16'h0000);
      tick();
      n_checks++; if (bus.ex_wb_result !== 16'h2222) begin n_errors++; $display("FAIL byp_wb got=%h exp=2222", bus.ex_wb_result); end
      bus.wb_ex_has_bypass = 1'b0;
      drive(MOV, 5'd20, 5'd5, 1'b0, 5'd6, 16'h0000, 16'h00AA);
      tick();
      n_checks++; if (bus.ex_wb_result !== 16'h00AA) begin n_errors++; $display("FAIL byp_imm_b got=%h exp=00aa", bus.ex_wb_result); end
      drive(AND_, 5'd20, 5'd6, 1'b1, 5'd7, 16'hFFFF, 16'h0000);
      tick();
      n_checks++; if (bus.ex_wb_result !== 16'h00AA) begin n_errors++; $display("FAIL byp_reg_b got=%h exp=00aa", bus.ex_wb_result); end
      bus.id_ex_valid = 1'b0;
      tick();
   endtask

   task automatic test_mul();
      int stall_cnt;
      int early_valid;
      stall_cnt   = 0;
      early_valid = 0;
      drive(MUL, 5'd20, 5'd21, 1'b0, 5'd9, 16'h0123, 16'h0045);
      tick();
      if (bus.ex_id_stall === 1'b1) stall_cnt++;
      if (bus.ex_wb_valid !== 1'b0) early_valid++;
      // decode holds the dependent instruction during the stall
      drive(ADD, 5'd9, 5'd21, 1'b0, 5'd8, 16'h0000, 16'h0001);
      for (int i = 1; i < 16; i++) begin
         tick();
         if (bus.ex_id_stall === 1'b1) stall_cnt++;
         if (bus.ex_wb_valid !== 1'b0) early_valid++;
      end
      tick();
      n_checks++; if (stall_cnt !== 16) begin n_errors++; $display("FAIL mul_stall_len got=%0d exp=16", stall_cnt); end
      n_checks++; if (early_valid !== 0) begin n_errors++; $display("FAIL mul_early_valid got=%0d exp=0", early_valid); end
      n_checks++; if (bus.ex_wb_valid !== 1'b1) begin n_errors++; $display("FAIL mul_valid got=%b exp=1", bus.ex_wb_valid); end
      n_checks++; if (bus.ex_wb_op !== MUL) begin n_errors++; $display("FAIL mul_op got=%b exp=%b", bus.ex_wb_op, MUL); end
      n_checks++; if (bus.ex_wb_result !== 16'h4E6F) begin n_errors++; $display("FAIL mul_result got=%h exp=4e6f", bus.ex_wb_result); end
      n_checks++; if (bus.ex_wb_nzcv !== 4'b0011) begin n_errors++; $display("FAIL mul_nzcv got=%b exp=0011", bus.ex_wb_nzcv); end
      n_checks++; if (bus.ex_id_stall !== 1'b0) begin n_errors++; $display("FAIL mul_stall_end got=%b exp=0", bus.ex_id_stall); end
      tick();
      n_checks++; if (bus.ex_wb_op !== ADD) begin n_errors++; $display("FAIL mul_next_op got=%b exp=%b", bus.ex_wb_op, ADD); end
      n_checks++; if (bus.ex_wb_result !== 16'h4E70) begin n_errors++; $display("FAIL mul_next_res got=%h exp=4e70", bus.ex_wb_result); end
      n_checks++; if (bus.ex_wb_nzcv !== 4'b0000) begin n_errors++; $display("FAIL mul_next_nzcv got=%b exp=0000", bus.ex_wb_nzcv); end
      bus.id_ex_valid = 1'b0;
      tick();
   endtask

   task automatic test_flags();
      drive(SUB, 5'd20, 5'd21, 1'b0, 5'd1, 16'h0005, 16'h0007);
      tick();
      n_checks++; if (bus.ex_wb_result !== 16'hFFFE) begin n_errors++; $display("FAIL sub_res got=%h exp=fffe", bus.ex_wb_result); end
      n_checks++; if (bus.ex_wb_nzcv !== 4'b1000) begin n_errors++; $display("FAIL sub_nzcv got=%b exp=1000", bus.ex_wb_nzcv); end
      drive(CMP, 5'd20, 5'd21, 1'b0, 5'd9, 16'h0007, 16'h0007);
      tick();
      n_checks++; if (bus.ex_wb_nzcv !== 4'b0110) begin n_errors++; $display("FAIL cmp_nzcv got=%b exp=0110", bus.ex_wb_nzcv); end
      drive(ADD, 5'd9, 5'd21, 1'b0, 5'd10, 16'h0042, 16'h0000);
      tick();
      n_checks++; if (bus.ex_wb_result !== 16'h0042) begin n_errors++; $display("FAIL cmp_nowrite got=%h exp=0042", bus.ex_wb_result); end
      drive(MSR, 5'd20, 5'd21, 1'b0, 5'd11, 16'h0002, 16'h0000);
      tick();
      n_checks++; if (bus.ex_wb_nzcv !== 4'b0010) begin n_errors++; $display("FAIL msr_nzcv got=%b exp=0010", bus.ex_wb_nzcv); end
      drive(ADC, 5'd20, 5'd21, 1'b0, 5'd12, 16'hFFFF, 16'h0000);
      tick();
      n_checks++; if (bus.ex_wb_result !== 16'h0000) begin n_errors++; $display("FAIL adc_res got=%h exp=0000", bus.ex_wb_result); end
      n_checks++; if (bus.ex_wb_nzcv !== 4'b0110) begin n_errors++; $display("FAIL adc_nzcv got=%b exp=0110", bus.ex_wb_nzcv); end
      drive(MRS, 5'd20, 5'd21, 1'b0, 5'd13, 16'h0000, 16'h0000);
      tick();
      n_checks++; if (bus.ex_wb_result !== 16'h0006) begin n_errors++; $display("FAIL mrs_res got=%h exp=0006", bus.ex_wb_result); end
   endtask

   task automatic test_shifts();
      drive(LSR, 5'd20, 5'd21, 1'b0, 5'd1, 16'h8001, 16'h0001);
      tick();
      n_checks++; if (bus.ex_wb_result !== 16'h4000) begin n_errors++; $display("FAIL lsr_res got=%h exp=4000", bus.ex_wb_result); end
      n_checks++; if (bus.ex_wb_nzcv !== 4'b0010) begin n_errors++; $display("FAIL lsr_nzcv got=%b exp=0010", bus.ex_wb_nzcv); end
      drive(ASR, 5'd20, 5'd21, 1'b0, 5'd2, 16'h8000, 16'h000F);
      tick();
      n_checks++; if (bus.ex_wb_result !== 16'hFFFF) begin n_errors++; $display("FAIL asr_res got=%h exp=ffff", bus.ex_wb_result); end
      n_checks++; if (bus.ex_wb_nzcv !== 4'b1000) begin n_errors++; $display("FAIL asr_nzcv got=%b exp=1000", bus.ex_wb_nzcv); end
      drive(LSL, 5'd20, 5'd21, 1'b0, 5'd3, 16'h8000, 16'h0001);
      tick();
      n_checks++; if (bus.ex_wb_nzcv !== 4'b0110) begin n_errors++; $display("FAIL lsl_nzcv got=%b exp=0110", bus.ex_wb_nzcv); end
      drive(LSL, 5'd20, 5'd21, 1'b0, 5'd4, 16'h0003, 16'h0000);
      tick();
      n_checks++; if (bus.ex_wb_result !== 16'h0003) begin n_errors++; $display("FAIL sh0_res got=%h exp=0003", bus.ex_wb_result); end
      n_checks++; if (bus.ex_wb_nzcv !== 4'b0010) begin n_errors++; $display("FAIL sh0_keepc got=%b exp=0010", bus.ex_wb_nzcv); end
      drive(ROR, 5'd20, 5'd21, 1'b0, 5'd5, 16'h0001, 16'h0001);
      tick();
      n_checks++; if (bus.ex_wb_result !== 16'h8000) begin n_errors++; $display("FAIL ror_res got=%h exp=8000", bus.ex_wb_result); end
      n_checks++; if (bus.ex_wb_nzcv !== 4'b1010) begin n_errors++; $display("FAIL ror_nzcv got=%b exp=1010", bus.ex_wb_nzcv); end
   endtask

   task automatic test_reset_mid_mul();
      int pulses;
      pulses = 0;
      drive(MUL, 5'd20, 5'd21, 1'b0, 5'd9, 16'h0003, 16'h0005);
      tick();
      bus.id_ex_valid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();
         if (bus.ex_wb_valid !== 1'b0) pulses++;
      end
      #2;
      reset = 1'b1;
      #1;
      n_checks++; if (bus.ex_id_stall !== 1'b0) begin n_errors++; $display("FAIL mrst_stall got=%b exp=0", bus.ex_id_stall); end
      n_checks++; if (bus.ex_wb_result !== 16'h0000) begin n_errors++; $display("FAIL mrst_result got=%h exp=0000", bus.ex_wb_result); end
      n_checks++; if (bus.ex_wb_nzcv !== 4'b0000) begin n_errors++; $display("FAIL mrst_nzcv got=%b exp=0000", bus.ex_wb_nzcv); end
      n_checks++; if (bus.ex_wb_reg_idx_dst !== 5'd0) begin n_errors++; $display("FAIL mrst_dst got=%0d exp=0", bus.ex_wb_reg_idx_dst); end
      n_checks++; if (bus.ex_wb_operand_b !== 16'h0000) begin n_errors++; $display("FAIL mrst_opb got=%h exp=0000", bus.ex_wb_operand_b); end
      tick();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.ex_wb_valid !== 1'b0) pulses++;
      end
      n_checks++; if (pulses !== 0) begin n_errors++; $display("FAIL mrst_no_pulse got=%0d exp=0", pulses); end
      drive(ADC, 5'd20, 5'd21, 1'b0, 5'd3, 16'h0002, 16'h0003);
      tick();
      n_checks++; if (bus.ex_wb_result !== 16'h0005) begin n_errors++; $display("FAIL mrst_next_res got=%h exp=0005", bus.ex_wb_result); end
      n_checks++; if (bus.ex_wb_valid !== 1'b1) begin n_errors++; $display("FAIL mrst_next_valid got=%b exp=1", bus.ex_wb_valid); end
      bus.id_ex_valid = 1'b0;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL timeout reached without completion");
      $fatal(1, "timeout");
   end

   initial begin
      n_checks               = 0;
      n_errors               = 0;
      reset                  = 1'b1;
      bus.id_ex_valid        = 1'b0;
      bus.id_ex_op           = NOP;
      bus.id_ex_reg_idx_a    = '0;
      bus.id_ex_reg_idx_b    = '0;
      bus.id_ex_b_is_reg     = 1'b0;
      bus.id_ex_reg_idx_dst  = '0;
      bus.id_ex_operand_a    = '0;
      bus.id_ex_operand_b    = '0;
      bus.wb_ex_has_bypass   = 1'b0;
      bus.wb_ex_bypass_reg   = '0;
      bus.wb_ex_bypass_value = '0;
      test_reset();
      test_back_to_back();
      test_bypass();
      test_mul();
      test_flags();
      test_shifts();
      test_reset_mid_mul();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
